dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 150 +++++++++++++++
 tb/tb_dm_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between two requesters
// (0 = core load/store, 1 = loader/debug). Reads take RD/RD_WAIT, word
// writes a single WR cycle, byte/halfword writes a read-modify-write.
// Optional build macro: DM_RR_ARB_EN selects round-robin arbitration on
// simultaneous requests (default build: fixed priority to requester 0).

module dm_arbiter #(
  parameter int MEMORY_BITS = 10
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD       = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WR       = 3'd3;
  localparam logic [2:0] RMW_RD   = 3'd4;
  localparam logic [2:0] RMW_WAIT = 3'd5;
  localparam logic [2:0] RMW_WR   = 3'd6;

  logic [2:0]  state;
  logic        lWe;
  logic [1:0]  lSize;
  logic [31:0] lAddr;
  logic [31:0] lWdata;
  logic [31:0] mergeWord;

  logic        grant;
  logic        selWe;
  logic [1:0]  selSize;
  logic [31:0] selAddr;
  logic [31:0] selWdata;
  logic [31:0] readMasked;
  logic        ackNow;
  logic        unusedLatched;

`ifdef DM_RR_ARB_EN
  logic lastGrant;

  // Remember who won the most recent grant; reset value lets requester 0 win first
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lastGrant <= 1'b1;
    end else if (state == IDLE && (req0 || req1)) begin
      lastGrant <= grant;
    end
  end
`endif

  // Pick a requester and mux its transaction fields
  always_comb begin
`ifdef DM_RR_ARB_EN
    grant = (req0 && req1) ? ~lastGrant : !req0;
`else
    grant = !req0;
`endif
    selWe    = grant ? we1    : we0;
    selSize  = grant ? size1  : size0;
    selAddr  = grant ? addr1  : addr0;
    selWdata = grant ? wdata1 : wdata0;
  end

  // Transaction FSM, latched request fields and RMW merge register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lWe       <= 1'b0;
      lSize     <= '0;
      lAddr     <= '0;
      lWdata    <= '0;
      mergeWord <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner  <= grant;
            lWe    <= selWe;
            lSize  <= selSize;
            lAddr  <= selAddr;
            lWdata <= selWdata;
            if (!selWe)          state <= RD;
            else if (selSize[1]) state <= WR;
            else                 state <= RMW_RD;
          end
        end
        RD:      state <= RD_WAIT;
        RD_WAIT: state <= IDLE;
        WR:      state <= IDLE;
        RMW_RD:  state <= RMW_WAIT;
        RMW_WAIT: begin
          // Only byte (00) and halfword (01) writes take the RMW path
          if (lSize == 2'b00) mergeWord <= {mem_rdata[31:8], lWdata[7:0]};
          else                mergeWord <= {mem_rdata[31:16], lWdata[15:0]};
          state <= RMW_WR;
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes, address/data, acks and size-masked read data
  always_comb begin
    mem_read_en  = (state == RD) || (state == RMW_RD);
    mem_write_en = (state == WR) || (state == RMW_WR);
    busy         = (state != IDLE);
    ackNow       = (state == RD_WAIT) || (state == WR) || (state == RMW_WR);
    ack0         = ackNow && !owner;
    ack1         = ackNow && owner;

    mem_addr = '0;
    mem_addr[MEMORY_BITS-1:0] = lAddr[MEMORY_BITS-1:0];
    mem_wdata = (state == RMW_WR) ? mergeWord : lWdata;

    case (lSize)
      2'b00:   readMasked = {24'h0, mem_rdata[7:0]};
      2'b01:   readMasked = {16'h0, mem_rdata[15:0]};
      default: readMasked = mem_rdata;
    endcase
    rdata0 = (state == RD_WAIT && !owner) ? readMasked : '0;
    rdata1 = (state == RD_WAIT && owner)  ? readMasked : '0;
  end

  // Direction and upper address bits are latched for completeness only
  assign unusedLatched = lWe ^ (^lAddr);

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scoreboard bench for dm_arbiter with a byte-array
// memory model (registered read, wraps modulo 2^MEMORY_BITS).

module tb_dm_arbiter;

  localparam int MB    = 10;
  localparam int MSIZE = 1 << MB;

  logic        clock = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [1:0]  size0, size1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner;

  always #5 clock = ~clock;

  dm_arbiter #(.MEMORY_BITS(MB)) dut (
    .clock(clock), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    int          ackCyc;
    logic [31:0] rdata;
    bit          chk;
  } expT;

  expT         q0[$];
  expT         q1[$];
  logic [7:0]  mem [MSIZE];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wrCount = 0;
  bit          rdPending = 0;
  logic [31:0] nextRd;
  logic [31:0] lastWrAddr, lastWrData, lastRdAddr;

  function automatic logic [31:0] readWord(input logic [31:0] a);
    int idx;
    idx = int'(a[MB-1:0]);
    return {mem[(idx+3)%MSIZE], mem[(idx+2)%MSIZE], mem[(idx+1)%MSIZE], mem[idx]};
  endfunction

  task automatic writeWord(input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[MB-1:0]);
    mem[idx]             = d[7:0];
    mem[(idx+1)%MSIZE]   = d[15:8];
    mem[(idx+2)%MSIZE]   = d[23:16];
    mem[(idx+3)%MSIZE]   = d[31:24];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic portCheck(input int p, input logic a, input logic [31:0] rd);
    expT e;
    if (a) begin
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
        check($sformatf("ack%0d_unexpected", p), {31'h0, a}, 32'h0);
      end else begin
        if (p == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("ack%0d_cycle", p), cyc, e.ackCyc);
        check($sformatf("ack%0d_owner", p), {31'h0, owner}, p);
        if (e.chk) check($sformatf("rdata%0d", p), rd, e.rdata);
      end
    end else begin
      check($sformatf("rdata%0d_idle_zero", p), rd, 32'h0);
    end
  endtask

  // One clock: memory read data appears just after the edge, checks at negedge
  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    if (rdPending) begin
      mem_rdata = nextRd;
      rdPending = 0;
    end
    @(negedge clock);
    check("strobe_overlap", {31'h0, mem_read_en & mem_write_en}, 32'h0);
    if (mem_write_en) begin
      wrCount++;
      lastWrAddr = mem_addr;
      lastWrData = mem_wdata;
      writeWord(mem_addr, mem_wdata);
    end
    if (mem_read_en) begin
      lastRdAddr = mem_addr;
      nextRd     = readWord(mem_addr);
      rdPending  = 1;
    end
    portCheck(0, ack0, rdata0);
    portCheck(1, ack1, rdata1);
  endtask

  task automatic drive(input int p, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req0 = 1'b1; we0 = we; size0 = sz; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; size1 = sz; addr1 = a; wdata1 = wd;
    end
  endtask

  task automatic push(input int p, input int lat, input logic [31:0] rd, input bit chk);
    expT e;
    e.ackCyc = cyc + lat;
    e.rdata  = rd;
    e.chk    = chk;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Step until every expected ack has been seen, releasing req after its last ack
  task automatic runUntilIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      step();
      if (ack0 && q0.size() == 0) req0 = 1'b0;
      if (ack1 && q1.size() == 0) req1 = 1'b0;
    end
    check("pending_after_run", q0.size() + q1.size(), 32'h0);
    req0 = 1'b0;
    req1 = 1'b0;
    q0.delete();
    q1.delete();
    step();
  endtask

  initial begin
    int wrBefore;
    for (int i = 0; i < MSIZE; i++) mem[i] = 8'h00;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; size0 = 0; size1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rdata = 0;
    #2;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_owner", {31'h0, owner}, 32'h0);
    check("rst_ack0", {31'h0, ack0}, 32'h0);
    check("rst_ack1", {31'h0, ack1}, 32'h0);
    check("rst_mem_read_en", {31'h0, mem_read_en}, 32'h0);
    check("rst_mem_write_en", {31'h0, mem_write_en}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    step();
    step();
    rst = 1'b0;

    // Word write then word read, driven in the first IDLE cycle after reset
    drive(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    push(0, 1, 32'h0, 0);
    runUntilIdle(20);
    check("wr_addr_0x10", lastWrAddr, 32'h10);
    check("wr_data_0x10", lastWrData, 32'hDEADBEEF);
    drive(0, 1'b0, 2'b10, 32'h10, 32'h0);
    push(0, 2, 32'hDEADBEEF, 1);
    runUntilIdle(20);

    // Byte write by requester 1 through RMW, then sub-word reads
    writeWord(32'h20, 32'h11223344);
    drive(1, 1'b1, 2'b00, 32'h20, 32'h000000AB);
    push(1, 3, 32'h0, 0);
    runUntilIdle(20);
    check("rmw_byte_data", lastWrData, 32'h112233AB);
    check("rmw_byte_mem", readWord(32'h20), 32'h112233AB);
    drive(0, 1'b0, 2'b01, 32'h20, 32'h0);
    push(0, 2, 32'h000033AB, 1);
    runUntilIdle(20);
    drive(1, 1'b0, 2'b00, 32'h23, 32'h0);
    push(1, 2, 32'h00000011, 1);
    runUntilIdle(20);

    // Halfword RMW ignores upper write-data bits
    writeWord(32'h40, 32'hAABBCCDD);
    drive(0, 1'b1, 2'b01, 32'h40, 32'h12345678);
    push(0, 3, 32'h0, 0);
    runUntilIdle(20);
    check("rmw_half_mem", readWord(32'h40), 32'hAABB5678);

    // Address truncation to MEMORY_BITS and wraparound of an unaligned read
    drive(0, 1'b1, 2'b10, 32'h12345404, 32'hA5A55A5A);
    push(0, 1, 32'h0, 0);
    runUntilIdle(20);
    check("wr_addr_trunc", lastWrAddr, 32'h4);
    writeWord(32'h3FC, 32'h87654321);
    writeWord(32'h000, 32'h44332211);
    drive(1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0);
    push(1, 2, 32'h22118765, 1);
    runUntilIdle(20);
    check("rd_addr_wrap", lastRdAddr, 32'h3FE);

    // Simultaneous requests for two back-to-back transactions
    drive(0, 1'b1, 2'b10, 32'h50, 32'h11110000);
    drive(1, 1'b1, 2'b10, 32'h60, 32'h22220000);
`ifdef DM_RR_ARB_EN
    push(0, 1, 32'h0, 0);
    push(1, 3, 32'h0, 0);
    push(0, 5, 32'h0, 0);
`else
    push(0, 1, 32'h0, 0);
    push(0, 3, 32'h0, 0);
    push(1, 5, 32'h0, 0);
`endif
    runUntilIdle(30);
    check("conflict_mem_0x50", readWord(32'h50), 32'h11110000);
    check("conflict_mem_0x60", readWord(32'h60), 32'h22220000);

    // Requester 1 arrives while requester 0 read is in RD
    writeWord(32'h70, 32'h0BADF00D);
    drive(0, 1'b0, 2'b11, 32'h70, 32'h0);
    push(0, 2, 32'h0BADF00D, 1);
    step();
    check("rd_state_busy", {31'h0, busy}, 32'h1);
    drive(1, 1'b0, 2'b00, 32'h71, 32'h0);
    push(1, 4, 32'h000000F0, 1);
    runUntilIdle(30);

    // Reset during RMW_WAIT abandons the byte write
    writeWord(32'h30, 32'h11223344);
    wrBefore = wrCount;
    drive(1, 1'b1, 2'b00, 32'h30, 32'h00000055);
    step();
    step();
    check("pre_rst_owner", {31'h0, owner}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_owner", {31'h0, owner}, 32'h0);
    check("midrst_ack1", {31'h0, ack1}, 32'h0);
    check("midrst_mem_read_en", {31'h0, mem_read_en}, 32'h0);
    check("midrst_mem_write_en", {31'h0, mem_write_en}, 32'h0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_mem_wdata", mem_wdata, 32'h0);
    check("midrst_rdata1", rdata1, 32'h0);
    req1 = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rst_no_write_count", wrCount, wrBefore);
    check("rst_mem_0x30", readWord(32'h30), 32'h11223344);
    drive(0, 1'b0, 2'b10, 32'h30, 32'h0);
    push(0, 2, 32'h11223344, 1);
    runUntilIdle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
